// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one div_16 divider among N requesters
module div_arbiter #(
    parameter int          N         = 4,
    parameter int          TIMEOUT   = 64,
    parameter logic [15:0] DZ_RESULT = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [16*N-1:0] a_in,
    input  logic [16*N-1:0] b_in,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rsp_valid,
    output logic [15:0]     rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic            div_init,
    output logic [15:0]     div_A,
    output logic [15:0]     div_B,
    input  logic [15:0]     div_result,
    input  logic            div_done
);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  ptr, winner, pick;
    logic [IW:0]    cand;
    logic           found;
    logic [15:0]    a_pick, b_pick;
    logic [CW-1:0]  tmo_cnt;
    logic           seen_low;
    logic           accept, expire;

    // First requester at or above ptr, wrapping at N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + IW1'(k);
            if (cand >= IW1'(N))
                cand = cand - IW1'(N);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    assign a_pick = a_in[16*pick +: 16];
    assign b_pick = b_in[16*pick +: 16];

    // A done level left over from the previous operation only counts after it has been seen low.
    assign accept = (state == WAIT) && div_done && seen_low;
    assign expire = (state == WAIT) && (tmo_cnt == CW'(TIMEOUT - 1));

    assign div_init  = (state == LAUNCH);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESPOND) ? gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = (b_pick == 16'd0) ? RESPOND : LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (accept || expire) state_nx = RESPOND;
            RESPOND: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            winner   <= '0;
            gnt      <= '0;
            div_A    <= '0;
            div_B    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            tmo_cnt  <= '0;
            seen_low <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        gnt    <= {{(N-1){1'b0}}, 1'b1} << pick;
                        div_A  <= a_pick;
                        div_B  <= b_pick;
                        if (b_pick == 16'd0) begin
                            rsp_data <= DZ_RESULT;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    tmo_cnt  <= '0;
                    seen_low <= 1'b0;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (!div_done)
                        seen_low <= 1'b1;
                    if (accept) begin
                        rsp_data <= div_result;
                        rsp_err  <= 1'b0;
                    end else if (expire) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESPOND: begin
                    gnt <= '0;
                    ptr <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized self-checking bench for div_arbiter
module tb_div_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [16*N-1:0] a_in, b_in;
    logic [N-1:0]    gnt, rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err, busy, div_init;
    logic [15:0]     div_A, div_B, div_result;
    logic            div_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, init_cnt = 0, init_cyc = 0, rsp_cnt = 0;
    int rr_ptr = 0;

    // divider model controls
    int  hi_at = 17, lo_at = -1, mcnt = -1;
    bit  stale = 0, hang = 0;
    logic [15:0] ma, mb;
    logic [15:0] ta [N];
    logic [15:0] tb_ [N];

    div_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .DZ_RESULT(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .div_init(div_init), .div_A(div_A), .div_B(div_B),
        .div_result(div_result), .div_done(div_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (div_init === 1'b1) begin
            init_cnt++;
            init_cyc = cyc;
        end
        if (rsp_valid != '0)
            rsp_cnt++;
    end

    initial begin
        div_done   = 1'b0;
        div_result = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                div_done = 1'b0; div_result = '0; mcnt = -1;
            end else if (div_init) begin
                mcnt = 0; ma = div_A; mb = div_B;
                if (!stale) div_done = 1'b0;
            end else if (mcnt >= 0) begin
                mcnt++;
                if (mcnt == lo_at) div_done = 1'b0;
                if (!hang && mcnt == hi_at) begin
                    div_done   = 1'b1;
                    div_result = (mb == 0) ? 16'hFFFF : ma / mb;
                    mcnt       = -1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int idx, input logic [15:0] a, input logic [15:0] b);
        a_in[16*idx +: 16] = a;
        b_in[16*idx +: 16] = b;
        ta[idx]  = a;
        tb_[idx] = b;
    endtask

    function automatic int rr_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
        return -1;
    endfunction

    task automatic exp_result(input int idx, output logic [15:0] d, output logic e);
        if (tb_[idx] == 0)  begin d = 16'hFFFF; e = 1'b1; end
        else if (hang)      begin d = 16'h0;    e = 1'b1; end
        else                begin d = ta[idx] / tb_[idx]; e = 1'b0; end
    endtask

    task automatic expect_rsp(input string tag, input int idx, output int at);
        bit ok;
        logic [15:0] ed;
        logic ee;
        ok = 0; at = 0;
        exp_result(idx, ed, ee);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin ok = 1; at = cyc; break; end
        end
        if (!ok) chk({tag, "_no_rsp"}, 32'd0, 32'd1);
        else begin
            chk({tag, "_vld"},  32'(rsp_valid), 32'(1 << idx));
            chk({tag, "_gnt"},  32'(gnt),       32'(1 << idx));
            chk({tag, "_data"}, 32'(rsp_data),  32'(ed));
            chk({tag, "_err"},  32'(rsp_err),   32'(ee));
        end
        req[idx] = 1'b0;
        rr_ptr   = (idx + 1) % N;
    endtask

    initial begin
        int at, c0, n0, r0, w;
        logic [N-1:0] mask;
        rst = 1'b0; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_div_init", 32'(div_init), 0);
        chk("rst_div_ab", {div_A, div_B}, 0);
        rst = 1'b1;

        // single operation
        set_op(0, 16'd100, 16'd7);
        @(negedge clk); req[0] = 1'b1;
        expect_rsp("single", 0, at);
        chk("single_lat", 32'(at - init_cyc), 32'd18);
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 0);

        // stale done held high from the previous op
        stale = 1; lo_at = 2; hi_at = 17;
        set_op(0, 16'd9, 16'd3);
        @(negedge clk); req[0] = 1'b1;
        expect_rsp("stale", 0, at);
        chk("stale_lat", 32'(at - init_cyc), 32'd18);
        stale = 0; lo_at = -1;

        // divide by zero never starts the divider
        n0 = init_cnt;
        set_op(2, 16'd55, 16'd0);
        @(negedge clk); req[2] = 1'b1; c0 = cyc;
        expect_rsp("dz", 2, at);
        chk("dz_lat", 32'(at - c0), 32'd1);
        chk("dz_no_init", 32'(init_cnt - n0), 0);

        // divider hang
        hang = 1;
        set_op(3, 16'd1000, 16'd10);
        @(negedge clk); req[3] = 1'b1;
        expect_rsp("tmo", 3, at);
        chk("tmo_lat", 32'(at - init_cyc), 32'(TIMEOUT + 1));
        hang = 0;
        set_op(0, 16'd50, 16'd5);
        @(negedge clk); req[0] = 1'b1;
        expect_rsp("after_tmo", 0, at);

        // reset in the middle of WAIT
        set_op(1, 16'd200, 16'd3);
        @(negedge clk); req[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        r0 = rsp_cnt;
        #2 rst = 1'b0; req = '0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rsp", {15'd0, rsp_err, rsp_data}, 0);
        chk("mid_rst_div_ab", {div_A, div_B}, 0);
        @(negedge clk); #2 rst = 1'b1;
        rr_ptr = 0;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_rsp", 32'(rsp_cnt - r0), 0);

        // continuous round robin, each requester re-raises right after its response
        for (int i = 0; i < N; i++) set_op(i, 16'(1000 + 37 * i), 16'(i + 3));
        hi_at = 6;
        req = '1;
        for (int s = 0; s < 5; s++) begin
            w = rr_pick(req);
            expect_rsp($sformatf("rr%0d", s), w, at);
            @(negedge clk); req[w] = 1'b1;
        end
        req = '0;
        repeat (40) @(negedge clk);

        // randomized request sets
        for (int it = 0; it < 30; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_op(i, 16'($urandom), ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            hi_at = $urandom_range(3, 40);
            stale = $urandom_range(0, 1);
            lo_at = stale ? $urandom_range(1, hi_at - 1) : -1;
            @(negedge clk); req = mask;
            while (req != '0) begin
                w = rr_pick(req);
                expect_rsp($sformatf("rnd%0d", it), w, at);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
